// File: rtl/seg_pkg.sv
// Shared types and constants for the segment address translator and its
// users of the segment register file.
package seg_pkg;

    localparam int DEF_ADDR_W    = 24;
    localparam int DEF_SEG_SHIFT = 8;
    localparam int DEF_OFS_W     = 16;
    localparam int SEG_W         = 16;

    typedef logic [1:0]            seg_id_t;
    typedef logic [SEG_W-1:0]      seg_t;
    typedef logic [DEF_ADDR_W-1:0] phys_addr_t;

    localparam seg_id_t SEG_ID_0 = 2'd0;
    localparam seg_id_t SEG_ID_1 = 2'd1;
    localparam seg_id_t SEG_ID_2 = 2'd2;
    localparam seg_id_t SEG_ID_3 = 2'd3;

    localparam seg_t SEG_RESET_1 = 16'hFFFF;

endpackage

// File: rtl/pipe_stage.sv
// Generic valid/ready register slice: loads when empty or when the consumer
// takes the current word, otherwise holds data and valid stable.
module pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            // A bubble leaves the old word in place; only valid matters then.
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/segment_addr_translator.sv
// Translates (segment id, offset) requests into physical bus addresses
// through a two-stage select/add pipeline with register-file write snooping.
module segment_addr_translator
    import seg_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int SEG_SHIFT = DEF_SEG_SHIFT,
    parameter int OFS_W     = DEF_OFS_W
) (
    input  logic              clk,
    input  logic              reset,
    input  seg_t              seg_regs [4],
    input  logic              seg_we,
    input  seg_id_t           seg_write_id,
    input  seg_t              seg_write_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  seg_id_t           req_seg,
    input  logic [OFS_W-1:0]  req_offset,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_wrap
);

    // Handshake: a word moves across any interface in a cycle where valid and
    // ready are both high at the clock edge; a producer holding valid keeps its
    // data stable until then, and ready never waits on valid of the same port.

    localparam int S1_W = SEG_W + OFS_W;
    localparam int S2_W = ADDR_W + 1;

    seg_t            seg_sel;
    logic [S1_W-1:0] s1_in;
    logic [S1_W-1:0] s1_q;
    logic            s1_valid;
    logic            s2_in_ready;
    logic [S2_W-1:0] sum;
    logic [S2_W-1:0] s2_q;

    // A write landing in the accept cycle wins over the stale register value.
    always_comb begin
        seg_sel = seg_regs[req_seg];
        if (seg_we && (seg_write_id == req_seg)) seg_sel = seg_write_data;
    end

    assign s1_in = {seg_sel, req_offset};

    pipe_stage #(.W(S1_W)) u_s1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (req_valid),
        .in_ready  (req_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_in_ready),
        .out_data  (s1_q)
    );

    // One extra bit above the address catches the carry out as the wrap flag.
    assign sum = (S2_W'(s1_q[S1_W-1 -: SEG_W]) << SEG_SHIFT)
               + S2_W'(s1_q[OFS_W-1:0]);

    pipe_stage #(.W(S2_W)) u_s2 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (s1_valid),
        .in_ready  (s2_in_ready),
        .in_data   (sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign out_addr = s2_q[ADDR_W-1:0];
    assign out_wrap = s2_q[ADDR_W];

endmodule
